// File: rtl/mem_resp_dummy.sv
// -----------------------------------------------------------------------------
// mem_resp_dummy
// Behavioural memory-side responder for the cache <-> memory-controller command
// port. A command (valid/rw/addr/wdata) is latched in IDLE, held for LATENCY
// clock edges, then completed with a single-cycle registered ready pulse. Writes
// commit to a small backing store and reads return the stored line, so
// cache-side initiators can run write-then-read checks with deterministic timing.
//
// Parameters
//   LATENCY  edges from command accept to ready assertion (legal 1..63)
//   IDX_W    backing-store index width, depth = 2**IDX_W lines of 256 bits
//   IDX_LSB  lowest address bit used as line index
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   mem_data_wr1     [255:0] write data from initiator
//   mem_data_rd1     [255:0] read data, valid while ready=1 on a read, then held
//   mem_data_addr1   [27:0]  command address
//   mem_rw_data1     1 = write, 0 = read
//   mem_valid_data1  command valid, held by initiator until ready
//   mem_ready_data1  one-cycle registered completion pulse
//   wr_count         [15:0] completed writes, saturating
//   rd_count         [15:0] completed reads, saturating
//   uninit_err       sticky flag: read of a never-written line
//
// Optional feature
//   MEM_RESP_UNINIT_CHK_EN  when defined, keeps a per-line written bit; reads of
//                           unwritten lines return zero and set uninit_err.
//                           When undefined, uninit_err is tied low.
// -----------------------------------------------------------------------------
module mem_resp_dummy #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 4,
    parameter int IDX_LSB = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] mem_data_wr1,
    output logic [255:0] mem_data_rd1,
    input  logic [27:0]  mem_data_addr1,
    input  logic         mem_rw_data1,
    input  logic         mem_valid_data1,
    output logic         mem_ready_data1,
    output logic [15:0]  wr_count,
    output logic [15:0]  rd_count,
    output logic         uninit_err
);

    localparam int         DEPTH  = 1 << IDX_W;
    localparam logic [5:0] LAT_M1 = 6'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 63) begin : g_bad_latency
        $error("mem_resp_dummy: LATENCY=%0d is outside 1..63", LATENCY);
    end

    if (IDX_LSB + IDX_W > 28) begin : g_bad_index
        $error("mem_resp_dummy: index field exceeds the 28-bit address");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [5:0]         cnt;
    logic [5:0]         cnt_nxt;
    logic               accept;

    // Command captured at accept; inputs are ignored until the response retires.
    logic               cmd_rw;
    logic [IDX_W-1:0]   cmd_idx;
    logic [255:0]       cmd_wdata;

    logic [255:0]       store [DEPTH];
    logic [255:0]       rd_line;

    // Only the index field of the address is meaningful; the remaining bits alias.
    logic               addr_unused;
    assign addr_unused = ^mem_data_addr1;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid_data1) begin
                    accept    = 1'b1;
                    cnt_nxt   = LAT_M1;
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state, command latch, ready pulse and completion counters.
    // The response edge is the edge taken while in RESP, so ready rises exactly
    // LATENCY edges after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            mem_ready_data1 <= 1'b0;
            wr_count        <= '0;
            rd_count        <= '0;
            cmd_rw          <= 1'b0;
            cmd_idx         <= '0;
            cmd_wdata       <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            mem_ready_data1 <= (state == RESP);
            if (accept) begin
                cmd_rw    <= mem_rw_data1;
                cmd_idx   <= mem_data_addr1[IDX_LSB +: IDX_W];
                cmd_wdata <= mem_data_wr1;
            end
            if (state == RESP) begin
                if (cmd_rw) begin
                    if (wr_count != 16'hFFFF) begin
                        wr_count <= wr_count + 16'd1;
                    end
                end else begin
                    if (rd_count != 16'hFFFF) begin
                        rd_count <= rd_count + 16'd1;
                    end
                end
            end
        end
    end

`ifdef MEM_RESP_UNINIT_CHK_EN
    logic [DEPTH-1:0] written;

    assign rd_line = written[cmd_idx] ? store[cmd_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written    <= '0;
            uninit_err <= 1'b0;
        end else if (state == RESP) begin
            if (cmd_rw) begin
                written[cmd_idx] <= 1'b1;
            end else if (!written[cmd_idx]) begin
                uninit_err <= 1'b1;
            end
        end
    end
`else
    assign rd_line    = store[cmd_idx];
    assign uninit_err = 1'b0;
`endif

    // Backing store and read-data register. Read data is only reloaded by the
    // next read response, so it stays stable after ready drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            mem_data_rd1 <= '0;
        end else if (state == RESP) begin
            if (cmd_rw) begin
                store[cmd_idx] <= cmd_wdata;
            end else begin
                mem_data_rd1 <= rd_line;
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_dummy.sv
module tb_mem_resp_dummy;

    localparam int LAT0 = 4;

    localparam logic [255:0] D0 = {8{32'hA5A5_0001}};
    localparam logic [255:0] D1 = {8{32'h1111_2222}};
    localparam logic [255:0] D2 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] D3 = {8{32'h0F0F_3333}};
    localparam logic [255:0] D4 = {8{32'h4444_ABCD}};
    localparam logic [255:0] D5 = {8{32'h5555_0000}};
    localparam logic [255:0] D6 = {8{32'h6666_F00D}};
    localparam logic [255:0] D7 = {8{32'h7777_CAFE}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [255:0] wdata_i = '0;
    logic [27:0]  addr_i = '0;
    logic         rw_i = 1'b0;
    logic         valid0 = 1'b0;
    logic         valid1 = 1'b0;

    logic [255:0] rd0, rd1;
    logic         ready0, ready1;
    logic [15:0]  wc0, rc0, wc1, rc1;
    logic         err0, err1;

    always #5 clk = ~clk;

    mem_resp_dummy #(.LATENCY(LAT0), .IDX_W(4), .IDX_LSB(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_data_wr1(wdata_i), .mem_data_rd1(rd0), .mem_data_addr1(addr_i),
        .mem_rw_data1(rw_i), .mem_valid_data1(valid0), .mem_ready_data1(ready0),
        .wr_count(wc0), .rd_count(rc0), .uninit_err(err0)
    );

    mem_resp_dummy #(.LATENCY(1), .IDX_W(4), .IDX_LSB(3)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .mem_data_wr1(wdata_i), .mem_data_rd1(rd1), .mem_data_addr1(addr_i),
        .mem_rw_data1(rw_i), .mem_valid_data1(valid1), .mem_ready_data1(ready1),
        .wr_count(wc1), .rd_count(rc1), .uninit_err(err1)
    );

    typedef struct packed {
        logic         rw;
        logic [255:0] data;
    } exp_t;

    exp_t         q[$];
    logic [255:0] model [16];
    logic         written_m [16];
    logic         exp_err_sticky;
    int           total = 0;
    int           bad = 0;

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            model[i]     = '0;
            written_m[i] = 1'b0;
        end
        exp_err_sticky = 1'b0;
        q.delete();
    endtask

    // Reference behaviour: line index is addr[6:3]; reset leaves every line zero.
    task automatic push_exp(input logic rw, input logic [27:0] a, input logic [255:0] d);
        exp_t       e;
        logic [3:0] idx;
        idx  = a[6:3];
        e.rw = rw;
        if (rw) begin
            model[idx]     = d;
            written_m[idx] = 1'b1;
            e.data         = d;
        end else begin
            e.data = model[idx];
            if (!written_m[idx]) exp_err_sticky = 1'b1;
        end
        q.push_back(e);
    endtask

    function automatic logic exp_err();
`ifdef MEM_RESP_UNINIT_CHK_EN
        return exp_err_sticky;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_cmd(input logic rw, input logic [27:0] a, input logic [255:0] d);
        @(negedge clk);
        rw_i    = rw;
        addr_i  = a;
        wdata_i = d;
        valid0  = 1'b1;
        push_exp(rw, a, d);
        @(posedge clk);
        #1 valid0 = 1'b0;
    endtask

    // Edges from accept to first ready sample (-1 on timeout) and ready one cycle later.
    task automatic wait_resp(output int lat, output logic [255:0] rd, output logic after);
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (ready0) begin
                lat = i - 1;
                rd  = rd0;
                break;
            end
        end
        @(negedge clk);
        after = ready0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready0); end
        total++; if (rd0 !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rd0); end
        total++; if ({wc0, rc0} !== 32'd0) begin bad++; $display("FAIL reset_counts: got wr=%0d rd=%0d want 0", wc0, rc0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err0); end
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        int lat; logic [255:0] rd; logic after;
        send_cmd(1'b1, 28'h0001000, D0);
        wait_resp(lat, rd, after);
        void'(q.pop_front());
        total++; if (lat !== LAT0) begin bad++; $display("FAIL write_latency: got %0d want %0d", lat, LAT0); end
        total++; if (after !== 1'b0) begin bad++; $display("FAIL write_ready_width: ready still %b one cycle later, want 0", after); end
        total++; if (wc0 !== 16'd1) begin bad++; $display("FAIL write_count: got %0d want 1", wc0); end
        total++; if (rc0 !== 16'd0) begin bad++; $display("FAIL write_rdcount: got %0d want 0", rc0); end
    endtask

    task automatic test_read();
        int lat; logic [255:0] rd; logic after; exp_t e;
        send_cmd(1'b0, 28'h0001000, '0);
        wait_resp(lat, rd, after);
        e = q.pop_front();
        total++; if (lat !== LAT0) begin bad++; $display("FAIL read_latency: got %0d want %0d", lat, LAT0); end
        total++; if (rd !== e.data) begin bad++; $display("FAIL read_data: got %h want %h", rd, e.data); end
        total++; if (rd0 !== e.data) begin bad++; $display("FAIL read_hold: got %h want %h", rd0, e.data); end
        total++; if (rc0 !== 16'd1) begin bad++; $display("FAIL read_count: got %0d want 1", rc0); end
    endtask

    task automatic test_alias();
        logic [27:0]  al_a [3] = '{28'h0001000, 28'h3001000, 28'h0001000};
        logic         al_rw [3] = '{1'b1, 1'b1, 1'b0};
        logic [255:0] al_d [3] = '{D1, D2, 256'h0};
        int lat; logic [255:0] rd; logic after; exp_t e;
        for (int i = 0; i < 3; i++) begin
            send_cmd(al_rw[i], al_a[i], al_d[i]);
            wait_resp(lat, rd, after);
            e = q.pop_front();
            total++; if (lat !== LAT0) begin bad++; $display("FAIL alias_latency[%0d]: got %0d want %0d", i, lat, LAT0); end
            if (!e.rw) begin
                total++; if (rd !== D2) begin bad++; $display("FAIL alias_data: got %h want %h", rd, D2); end
            end
        end
    endtask

    task automatic test_drop_valid();
        int lat; logic [255:0] rd; logic after; int extra; exp_t e;
        @(negedge clk);
        rw_i = 1'b1; addr_i = 28'h0001008; wdata_i = D3; valid0 = 1'b1;
        push_exp(1'b1, 28'h0001008, D3);
        @(posedge clk);
        #1;
        valid0 = 1'b0; rw_i = 1'b0; addr_i = 28'h0001010; wdata_i = ~D3;
        wait_resp(lat, rd, after);
        void'(q.pop_front());
        total++; if (lat !== LAT0) begin bad++; $display("FAIL drop_latency: got %0d want %0d", lat, LAT0); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL drop_extra_resp: got %0d want 0", extra); end
        send_cmd(1'b0, 28'h0001008, '0);
        wait_resp(lat, rd, after);
        e = q.pop_front();
        total++; if (rd !== e.data) begin bad++; $display("FAIL drop_latched_data: got %h want %h", rd, e.data); end
        total++; if ({wc0, rc0} !== {16'd4, 16'd3}) begin bad++; $display("FAIL drop_counts: got wr=%0d rd=%0d want 4/3", wc0, rc0); end
    endtask

    task automatic test_back_to_back();
        int n_rdy; int first_at; int second_at; exp_t e;
        @(negedge clk);
        rw_i = 1'b1; addr_i = 28'h0001018; wdata_i = D4; valid0 = 1'b1;
        push_exp(1'b1, 28'h0001018, D4);
        push_exp(1'b0, 28'h0001018, '0);
        @(posedge clk);
        #1 rw_i = 1'b0;
        n_rdy = 0; first_at = -1; second_at = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == LAT0 + 1) valid0 = 1'b0;
            @(negedge clk);
            if (ready0) begin
                n_rdy++;
                e = q.pop_front();
                if (n_rdy == 1) first_at = c;
                else begin
                    second_at = c;
                    total++; if (rd0 !== e.data) begin bad++; $display("FAIL b2b_read_data: got %h want %h", rd0, e.data); end
                end
            end
        end
        valid0 = 1'b0;
        total++; if (n_rdy !== 2) begin bad++; $display("FAIL b2b_resp_count: got %0d want 2", n_rdy); end
        total++; if (first_at !== LAT0) begin bad++; $display("FAIL b2b_first_edge: got %0d want %0d", first_at, LAT0); end
        total++; if (second_at !== 2 * LAT0 + 1) begin bad++; $display("FAIL b2b_second_edge: got %0d want %0d", second_at, 2 * LAT0 + 1); end
    endtask

    task automatic test_random();
        int lat; logic [255:0] rd; logic after; exp_t e;
        logic rw; logic [27:0] a; logic [255:0] d;
        for (int i = 0; i < 10; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = {4'($urandom), 17'($urandom), 4'($urandom_range(0, 15)), 3'($urandom)};
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            send_cmd(rw, a, d);
            wait_resp(lat, rd, after);
            e = q.pop_front();
            total++; if (lat !== LAT0) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT0); end
            if (!e.rw) begin
                total++; if (rd !== e.data) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, rd, e.data); end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [255:0] rd; logic after; int spurious;
        send_cmd(1'b1, 28'h0001000, D5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL rstw_ready: got %b want 0", ready0); end
        total++; if ({wc0, rc0} !== 32'd0) begin bad++; $display("FAIL rstw_counts: got wr=%0d rd=%0d want 0", wc0, rc0); end
        total++; if (rd0 !== '0) begin bad++; $display("FAIL rstw_rdata: got %h want 0", rd0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL rstw_err: got %b want 0", err0); end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready0) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("FAIL rstw_aborted: got %0d responses want 0", spurious); end
        send_cmd(1'b1, 28'h0001000, D6);
        wait_resp(lat, rd, after);
        void'(q.pop_front());
        total++; if (lat !== LAT0) begin bad++; $display("FAIL rstw_latency: got %0d want %0d", lat, LAT0); end
        total++; if (wc0 !== 16'd1) begin bad++; $display("FAIL rstw_count: got %0d want 1", wc0); end
    endtask

    task automatic test_uninit();
        int lat; logic [255:0] rd; logic after; exp_t e;
        send_cmd(1'b0, 28'h0001040, '0);
        wait_resp(lat, rd, after);
        e = q.pop_front();
        total++; if (rd !== e.data) begin bad++; $display("FAIL uninit_data: got %h want %h", rd, e.data); end
        total++; if (err0 !== exp_err()) begin bad++; $display("FAIL uninit_err: got %b want %b", err0, exp_err()); end
        send_cmd(1'b0, 28'h0001000, '0);
        wait_resp(lat, rd, after);
        e = q.pop_front();
        total++; if (rd !== e.data) begin bad++; $display("FAIL uninit_good_read: got %h want %h", rd, e.data); end
        total++; if (err0 !== exp_err()) begin bad++; $display("FAIL uninit_sticky: got %b want %b", err0, exp_err()); end
    endtask

    task automatic test_latency1();
        logic rws [2] = '{1'b1, 1'b0};
        int lat; logic after; exp_t e;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            rw_i = rws[t]; addr_i = 28'h0000020; wdata_i = D7; valid1 = 1'b1;
            push_exp(rws[t], 28'h0000020, D7);
            @(posedge clk);
            #1 valid1 = 1'b0;
            lat = -1;
            for (int i = 1; i <= 50; i++) begin
                @(negedge clk);
                if (ready1) begin lat = i - 1; break; end
            end
            e = q.pop_front();
            total++; if (lat !== 1) begin bad++; $display("FAIL lat1_latency[%0d]: got %0d want 1", t, lat); end
            if (!e.rw) begin
                total++; if (rd1 !== e.data) begin bad++; $display("FAIL lat1_data: got %h want %h", rd1, e.data); end
            end
            @(negedge clk);
            after = ready1;
            total++; if (after !== 1'b0) begin bad++; $display("FAIL lat1_ready_width[%0d]: got %b want 0", t, after); end
        end
        total++; if ({wc1, rc1} !== {16'd1, 16'd1}) begin bad++; $display("FAIL lat1_counts: got wr=%0d rd=%0d want 1/1", wc1, rc1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alias();
        test_drop_valid();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        test_uninit();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
